// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data load/store. Each access goes through IDLE -> BUSY_x -> IDLE. The
// winner's request is latched for the whole access, and sel steers the
// core's external address/write-data mux.
// Optional feature macro: MEM_ARB_RR_EN
//   defined   -> round-robin tie-break (last_grant register present)
//   undefined -> fixed priority, data wins ties
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                sel
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       grant_i;
  logic       grant_d;
  logic       we_q;

`ifdef MEM_ARB_RR_EN
  // 0 = fetch was granted last, 1 = data was granted last
  logic       last_grant;
`endif

  // Grant decision, only taken while IDLE
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
        if (last_grant) grant_i = 1'b1;
        else            grant_d = 1'b1;
`else
        grant_d = 1'b1;
`endif
      end else begin
        grant_i = if_req;
        grant_d = d_req;
      end
    end
  end

  // Next-state logic; requests are ignored while busy
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latch the winner's request and owner select on the grant edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      we_q      <= 1'b0;
      sel       <= 1'b0;
    end else if (grant_d) begin
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_be    <= d_we ? d_be : '1;
      we_q      <= d_we;
      sel       <= 1'b1;
    end else if (grant_i) begin
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      mem_be    <= '1;
      we_q      <= 1'b0;
      sel       <= 1'b0;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember the last winner for the round-robin tie-break
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_grant <= 1'b1;
    else if (grant_d) last_grant <= 1'b1;
    else if (grant_i) last_grant <= 1'b0;
  end
`endif

  // Memory-side strobes and requester acks derive directly from state so an
  // asynchronous reset clears them without waiting for a clock edge
  always_comb begin
    mem_valid = (state == BUSY_I) || (state == BUSY_D);
    mem_we    = we_q && mem_valid;
    if_ack    = (state == BUSY_I) && mem_ready;
    d_ack     = (state == BUSY_D) && mem_ready;
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an expected-access scoreboard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .sel       (sel)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_d, input logic [31:0] addr, input logic we,
                      input logic [3:0] be, input logic [31:0] wdata);
    exp_t e;
    e.is_d = is_d; e.addr = addr; e.we = we; e.be = be; e.wdata = wdata;
    sbq.push_back(e);
  endtask

  // Runs cycles until an ack appears (bounded), checking the latched
  // memory-side values on every busy cycle against the scoreboard head.
  task automatic wait_ack(input int delay, input bit drop_d, output int cycles);
    exp_t        e;
    bit          done;
    int          busy_cnt;
    logic [31:0] rd;
    cycles   = 0;
    busy_cnt = 0;
    done     = 1'b0;
    chk("sb_nonempty", (sbq.size() > 0), 1);
    if (sbq.size() == 0) return;
    e = sbq[0];
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      cycles++;
      rd = $urandom;
      mem_rdata = rd;
      if (!mem_valid) begin
        busy_cnt  = 0;
        mem_ready = 1'b0;
      end else begin
        busy_cnt++;
        mem_ready = (busy_cnt > delay);
        if (drop_d && busy_cnt == 1) begin
          d_req  = 1'b0;
          d_addr = 32'h0000_BAD0;
          d_we   = ~d_we;
        end
      end
      #1;
      if (mem_valid) begin
        chk("busy_sel",  sel,    e.is_d);
        chk("busy_addr", mem_addr, e.addr);
        chk("busy_we",   mem_we, e.we);
        chk("busy_be",   mem_be, e.be);
        if (e.we) chk("busy_wdata", mem_wdata, e.wdata);
        chk("ack_vs_ready", (if_ack | d_ack), mem_ready);
      end else begin
        chk("idle_no_ack", (if_ack | d_ack), 0);
      end
      if (if_ack || d_ack) begin
        done = 1'b1;
        chk("ack_is_d", d_ack,  e.is_d);
        chk("ack_is_i", if_ack, !e.is_d);
        if (!e.is_d)    chk("if_rdata", if_rdata, rd);
        else if (!e.we) chk("d_rdata",  d_rdata,  rd);
        void'(sbq.pop_front());
      end
    end
    chk("ack_seen", done, 1);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_valid", mem_valid, 0);
    chk("rst_sel",   sel, 0);
    chk("rst_we",    mem_we, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_be",    mem_be, 0);
    chk("rst_acks",  {if_ack, d_ack}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Single fetch, memory ready on the first busy cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    push(1'b0, 32'h100, 1'b0, 4'hF, 32'h0);
    wait_ack(0, 1'b0, cyc);
    chk("fetch_latency", cyc, 1);
    @(negedge clk); if_req = 1'b0; #1;
    chk("fetch_idle_valid", mem_valid, 0);
    chk("fetch_idle_ack",   if_ack, 0);
    chk("fetch_idle_sel",   sel, 0);

    // Store with mem_ready delayed three cycles
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    push(1'b1, 32'h2000, 1'b1, 4'b0011, 32'hDEADBEEF);
    wait_ack(3, 1'b0, cyc);
    chk("store_latency", cyc, 4);
    @(negedge clk); d_req = 1'b0; d_we = 1'b0; #1;
    chk("store_single_ack", d_ack, 0);
    chk("store_idle_valid", mem_valid, 0);
    chk("store_idle_we",    mem_we, 0);
    chk("store_sel_hold",   sel, 1);

    // Both requesters held high across four accesses
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h400;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h500;
`ifdef MEM_ARB_RR_EN
    push(1'b0, 32'h400, 1'b0, 4'hF, 32'h0);
    push(1'b1, 32'h500, 1'b0, 4'hF, 32'h0);
    push(1'b0, 32'h400, 1'b0, 4'hF, 32'h0);
    push(1'b1, 32'h500, 1'b0, 4'hF, 32'h0);
`else
    for (int k = 0; k < 4; k++) push(1'b1, 32'h500, 1'b0, 4'hF, 32'h0);
`endif
    for (int k = 0; k < 4; k++) wait_ack(0, 1'b0, cyc);
`ifdef MEM_ARB_RR_EN
    @(negedge clk); if_req = 1'b0; d_req = 1'b0;
`else
    @(negedge clk); d_req = 1'b0;
    push(1'b0, 32'h400, 1'b0, 4'hF, 32'h0);
    wait_ack(0, 1'b0, cyc);
    @(negedge clk); if_req = 1'b0;
`endif

    // Asynchronous reset in the middle of a data access
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6000; d_wdata = 32'h1234_5678; d_be = 4'hC;
    mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("pre_rst_valid", mem_valid, 1);
    chk("pre_rst_sel",   sel, 1);
    if_req = 1'b1; if_addr = 32'h700;
    @(negedge clk);
    #3 rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("async_rst_valid", mem_valid, 0);
    chk("async_rst_sel",   sel, 0);
    chk("async_rst_dack",  d_ack, 0);
    chk("async_rst_we",    mem_we, 0);
    chk("async_rst_addr",  mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0; d_req = 1'b0; d_we = 1'b0;
    push(1'b0, 32'h700, 1'b0, 4'hF, 32'h0);
    wait_ack(1, 1'b0, cyc);
    chk("post_rst_latency", cyc, 2);
    @(negedge clk); if_req = 1'b0;

    // Requester drops d_req and changes d_addr mid-access
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    push(1'b1, 32'h3000, 1'b0, 4'hF, 32'h0);
    wait_ack(2, 1'b1, cyc);
    @(negedge clk); d_we = 1'b0; #1;
    chk("drop_idle_valid", mem_valid, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single femtoRV32 memory port between instruction fetch and data load/store. It sequences each access through a small FSM and latches the winner's address and write data. It also drives the shared select line that steers the core's 2:1 address and write-data muxes. It sits between the core's fetch/LSU stages and the unified memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  fetch complete, one-cycle pulse
- if_rdata  out  DATA_W  fetch data, valid when if_ack=1
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_ack  out  1  data access complete, one-cycle pulse
- d_rdata  out  DATA_W  load data, valid when d_ack=1
- mem_valid  out  1  access in progress to memory
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_be  out  DATA_W/8  latched byte enables; all-ones for fetch and load
- mem_ready  in  1  memory completes access this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- sel  out  1  current owner: 0=fetch, 1=data; drives the external 2:1 mux select

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- **IDLE:**
  - No request: stay in IDLE.
  - One request: grant it regardless of priority.
  - Both requests: grant per the tie rule in Configuration.
  - On grant, register the address (and for data, d_we, d_wdata, d_be). Update sel and last_grant, then move to BUSY_I or BUSY_D.
- **BUSY_x:**
  - mem_valid=1, and all mem_* outputs hold the latched values.
  - If mem_ready=0: stay.
  - If mem_ready=1: assert the owner's ack combinationally (if_ack = BUSY_I & mem_ready; d_ack = BUSY_D & mem_ready) and return to IDLE.
- **Read data:** if_rdata and d_rdata pass mem_rdata through combinationally. Their values are meaningful only with the matching ack.
- **Stores:** d_rdata is don't-care on the d_ack of a store.
- **Protocol violation:** a requester that drops req while BUSY does not abort the access. The access completes on latched values and the ack still pulses.
- **Asynchronous reset (including mid-access):**
  - State returns to IDLE; mem_valid=0, mem_we=0, sel=0, last_grant=1.
  - mem_addr, mem_wdata and mem_be are 0.
  - No ack is issued for the abandoned access.

## Timing
- Grant latency: a req seen in IDLE at edge N gives mem_valid=1 in cycle N+1.
- Completion: an ack in cycle M is the same cycle as mem_ready=1. The FSM is in IDLE in cycle M+1.
- Minimum access time is 2 cycles (grant cycle plus mem_ready in the first BUSY cycle).
- Back-to-back: at most 1 idle cycle between accesses. A req still high in the ack cycle is not re-sampled, because the FSM is not in IDLE that cycle.
- sel changes only on a grant edge and otherwise holds its last owner, including through IDLE.
- mem_valid never drops while mem_ready=0.

## Configuration
- Macro: MEM_ARB_RR_EN.
- **Defined:** round-robin tie-break.
  - When both requesters are pending in IDLE, grant the one not granted last (last_grant≠winner).
  - Reset value last_grant=1, so fetch wins the first tie.
- **Undefined:** fixed priority; data always wins ties. The last_grant register is not implemented.

## Test plan
- Reset, then if_req=1 with if_addr=0x100 and mem_ready high on the first BUSY cycle → mem_valid rises in cycle 1 with mem_addr=0x100 and sel=0. if_ack pulses in cycle 1 with if_rdata=mem_rdata.
- Store with d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011, mem_ready delayed 3 cycles → mem_we=1, mem_be=0011 and sel=1 are held stable for 4 cycles. d_ack pulses exactly once.
- if_req and d_req both held high for 4 accesses, MEM_ARB_RR_EN defined → grant order fetch, data, fetch, data.
- Same stimulus with MEM_ARB_RR_EN undefined → data wins every tie.
- Assert rst_n=0 mid-BUSY_D, before mem_ready → mem_valid=0, sel=0 and no d_ack, all immediately without waiting for a clock edge. After release, the pending if_req is granted.
- Drop d_req during BUSY_D and change d_addr → mem_addr keeps the latched value, and d_ack still pulses on mem_ready.
